// File: rtl/fft_pkg.sv
// fft_pkg: sample format, frame length and read-FSM states shared by the
// frame collector and the FFT wrapper.
package fft_pkg;

    localparam int SAMPLE_W = 16;
    localparam int FFT_LEN  = 256;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_e;

endpackage

// File: rtl/ffc_bank_ram.sv
// ffc_bank_ram: simple dual-port RAM, one synchronous write port and one
// asynchronous read port; holds both ping-pong banks as {bank, index}.
module ffc_bank_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_frame_collector.sv
// fft_frame_collector: ping-pong framer from an unstallable sample strobe to an
// Avalon-ST packet source. Define FFC_DROP_CNT_EN to add the drop_count output.
module fft_frame_collector
    import fft_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int FRAME_LEN = FFT_LEN,
    localparam int ADDR_W   = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
`ifdef FFC_DROP_CNT_EN
    output logic [15:0]       drop_count,
`endif
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    rd_state_e         state_q, state_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en, drop, set_full, clr_full, accept;

    assign wr_en    = in_valid && !flush && !bank_full_q[wr_bank_q];
    assign drop     = in_valid && !flush && bank_full_q[wr_bank_q];
    assign set_full = wr_en && (wr_idx_q == LAST);
    assign accept   = out_valid_q && out_ready;

    // rd_idx is 0 whenever the FSM is idle, so it addresses sample 0 there too
    ffc_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (2 * FRAME_LEN)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank_q, wr_idx_q}),
        .wr_data (in_data),
        .rd_addr ({rd_bank_q, rd_idx_q}),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_data_d  = out_data_q;
        clr_full    = 1'b0;
        if (state_q == IDLE) begin
            if (bank_full_q[rd_bank_q]) begin
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
                out_sop_d   = 1'b1;
                out_eop_d   = 1'b0;
                rd_idx_d    = rd_idx_q + 1'b1;
                state_d     = STREAM;
            end
        end else if (accept) begin
            if (out_eop_q) begin
                clr_full    = 1'b1;
                rd_bank_d   = ~rd_bank_q;
                out_valid_d = 1'b0;
                out_sop_d   = 1'b0;
                out_eop_d   = 1'b0;
                state_d     = IDLE;
            end else begin
                out_data_d = rd_data;
                out_sop_d  = 1'b0;
                out_eop_d  = (rd_idx_q == LAST);
                rd_idx_d   = rd_idx_q + 1'b1;
            end
        end
        if (flush) begin
            state_d     = IDLE;
            rd_idx_d    = '0;
            rd_bank_d   = 1'b0;
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
        end
    end

    // set and clear always target different banks, so both may land together
    always_comb begin
        bank_full_d = bank_full_q;
        if (set_full) bank_full_d[wr_bank_q] = 1'b1;
        if (clr_full) bank_full_d[rd_bank_q] = 1'b0;
        if (flush) bank_full_d = '0;
        wr_idx_d   = flush ? '0 : (wr_en ? wr_idx_q + 1'b1 : wr_idx_q);
        wr_bank_d  = flush ? 1'b0 : (wr_bank_q ^ set_full);
        overflow_d = drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef FFC_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = flush ? 16'h0 : ((drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'h1 : drop_cnt_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_cnt_q <= 16'h0;
        else drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_frame_collector.sv
// tb_fft_frame_collector: table vectors, directed corner sequences and a
// randomized run against a frame-queue reference model.
module tb_fft_frame_collector;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        out_valid, out_sop, out_eop, overflow;
    logic [15:0] out_data;
    logic        b_in_valid = 1'b0, b_flush = 1'b0, b_out_ready = 1'b0;
    logic [15:0] b_in_data = 16'h0;
    logic        b_out_valid, b_out_sop, b_out_eop, b_overflow;
    logic [15:0] b_out_data;
`ifdef FFC_DROP_CNT_EN
    logic [15:0] drop_count, b_drop_count;
`endif

    always #5 clk = ~clk;

    fft_frame_collector #(.FRAME_LEN(L)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
`ifdef FFC_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .overflow(overflow)
    );

    fft_frame_collector dut256 (
        .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_sop(b_out_sop), .out_eop(b_out_eop),
`ifdef FFC_DROP_CNT_EN
        .drop_count(b_drop_count),
`endif
        .overflow(b_overflow)
    );

    int n_total = 0;
    int n_pass  = 0;

    // reference model: completed frames queued flat, plus the frame being gathered
    logic [15:0] exp_q[$];
    logic [15:0] cur[$];
    logic [15:0] got[$];
    int          nfull = 0;
    int          pos = 0;
    bit          exp_ovf = 1'b0;

    typedef struct {
        bit          iv;
        logic [15:0] d;
        bit          rdy;
        bit          v, sop, eop;
        logic [15:0] od;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_total++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got_v, exp_v);
    endtask

    task automatic cycle(input bit iv, input logic [15:0] d, input bit fl, input bit rdy);
        bit acc, dropped;
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = rdy;
        dropped = !fl && iv && nfull == 2;
        acc = out_valid && rdy && !fl;
        if (acc) begin
            got.push_back(out_data);
            check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                check("beat", {out_sop, out_eop, out_data}, {pos == 0, pos == L - 1, exp_q[0]});
                void'(exp_q.pop_front());
                pos++;
                if (pos == L) begin
                    pos = 0;
                    nfull--;
                end
            end
        end
        if (fl) begin
            exp_q.delete();
            cur.delete();
            nfull = 0;
            pos = 0;
            exp_ovf = 1'b0;
        end else begin
            exp_ovf = dropped;
            if (iv && !dropped) cur.push_back(d);
            if (cur.size() == L) begin
                foreach (cur[i]) exp_q.push_back(cur[i]);
                cur.delete();
                nfull++;
            end
        end
        @(posedge clk);
        #1;
        check("overflow", 64'(overflow), 64'(exp_ovf));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            n++;
        end
        check("wait_valid", 64'(out_valid), 64'(1));
    endtask

    task automatic check_got(input string name, input int base, input int len);
        check({name, "_len"}, 64'(got.size()), 64'(len));
        for (int i = 0; i < len; i++)
            check({name, "_data"}, 64'(got.size() > i ? got[i] : 16'hDEAD), 64'(base + i));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          n_ovf, k;
        bit          rdy;
        logic [18:0] pre;

        tbl[0] = '{1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[5] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};
        tbl[6] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3};
        tbl[7] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd4};
        tbl[8] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[9] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, out_sop, out_eop, overflow, out_data}, 64'h0);
        check("reset_outputs_256", {b_out_valid, b_out_sop, b_out_eop, b_overflow, b_out_data}, 64'h0);
        reset_n = 1'b1;

        // single frame, latency and sop/eop placement
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].iv, tbl[i].d, 1'b0, tbl[i].rdy);
            check($sformatf("table_row%0d", i),
                  {out_valid, out_sop, out_eop, out_valid ? out_data : 16'h0},
                  {tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].od});
        end

        // both banks full, four drops, then drain in order
        got.delete();
        n_ovf = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 16'(i), 1'b0, 1'b0);
            if (overflow) n_ovf++;
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        if (overflow) n_ovf++;
        check("ovf_pulses", 64'(n_ovf), 64'(4));
        repeat (30) cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check_got("overflow_drain", 1, 8);

        // ready toggling: outputs frozen while stalled
        got.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(30 + i), 1'b0, 1'b0);
        wait_valid();
        for (int i = 0; i < 8; i++) begin
            rdy = (i % 2 == 0);
            pre = {out_valid, out_sop, out_eop, out_data};
            cycle(1'b0, 16'h0, 1'b0, rdy);
            if (!rdy) check("stall_hold", {out_valid, out_sop, out_eop, out_data}, pre);
        end
        check_got("stall", 30, 4);

        // flush mid-packet, then a fresh frame
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(40 + i), 1'b0, 1'b0);
        wait_valid();
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        cycle(1'b1, 16'h77, 1'b1, 1'b0);
        check("flush_valid", 64'(out_valid), 64'(0));
        got.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(20 + i), 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check_got("after_flush", 20, 4);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 63) == 0,
                  $urandom_range(0, 2) != 0);
        repeat (20) cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check("rand_drained", 64'(exp_q.size()), 64'(0));

        // default 256-sample frames, continuous ramp
        k = 0;
        n_ovf = 0;
        for (int n = 0; n < 800; n++) begin
            b_in_valid  = (n < 512);
            b_in_data   = 16'(n);
            b_out_ready = 1'b1;
            if (b_out_valid) begin
                check("ramp_beat", {b_out_sop, b_out_eop, b_out_data},
                      {k % 256 == 0, k % 256 == 255, 16'(k)});
                k++;
            end
            @(posedge clk);
            #1;
            if (b_overflow) n_ovf++;
        end
        check("ramp_len", 64'(k), 64'(512));
        check("ramp_ovf", 64'(n_ovf), 64'(0));

`ifdef FFC_DROP_CNT_EN
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 70000; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
        check("drop_saturate", 64'(drop_count), 64'(16'hFFFF));
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        check("drop_flush", 64'(drop_count), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
